// File: rtl/jtag_dpacc_dr.sv
// jtag_dpacc_dr: JTAG debug-port access data register bridging scan commands onto a req/ack bus.
module jtag_dpacc_dr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tdi,
  input  logic                  state_test_logic_reset,
  input  logic                  state_capture_dr,
  input  logic                  state_shift_dr,
  input  logic                  state_update_dr,
  input  logic                  insn_jdpacc_select,
  output logic                  jdpacc_tdo,
  output logic                  dp_req,
  output logic                  dp_write,
  output logic [ADDR_WIDTH-1:0] dp_addr,
  output logic [DATA_WIDTH-1:0] dp_wdata,
  input  logic                  dp_ack,
  input  logic                  dp_err,
  input  logic [DATA_WIDTH-1:0] dp_rdata
);
  localparam int DR_WIDTH = 2 + ADDR_WIDTH + DATA_WIDTH;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [DR_WIDTH-1:0] dr_q, dr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic err_q, err_d, write_q, write_d, busy;
  logic [1:0] op;
  logic upd, acc, ack, accept, overrun;
  assign op = dr_q[1:0];
  assign upd = insn_jdpacc_select & state_update_dr;
  assign acc = upd & (op[0] ^ op[1]);
  assign ack = dp_ack & (state_q == REQ);
  // Busy is judged after this cycle's ack, so an update coinciding with ack chains back-to-back.
  assign accept = acc & ((state_q == IDLE) | dp_ack);
  assign overrun = acc & ~accept;
  always_ff @(posedge tck or posedge trst)
    if (trst) state_q <= IDLE;
    else if (state_test_logic_reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = accept ? REQ : ack ? IDLE : state_q;
  always_comb begin
    busy = state_q == REQ;
    dp_req = busy;
  end
  always_comb begin
    dr_d = !insn_jdpacc_select ? dr_q
         : state_capture_dr ? {{ADDR_WIDTH{1'b0}}, rdata_q, err_q, busy}
         : state_shift_dr ? {tdi, dr_q[DR_WIDTH-1:1]} : dr_q;
    rdata_d = (ack & ~write_q) ? dp_rdata : rdata_q;
    err_d = ((ack & dp_err) | overrun) ? 1'b1 : (upd & op == 2'b11) ? 1'b0 : err_q;
    addr_d = accept ? dr_q[ADDR_WIDTH+1:2] : addr_q;
    wdata_d = accept ? dr_q[DR_WIDTH-1:ADDR_WIDTH+2] : wdata_q;
    write_d = accept ? op[1] : write_q;
  end
  always_ff @(posedge tck or posedge trst)
    if (trst) begin
      dr_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (state_test_logic_reset) begin
      dr_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      dr_q <= dr_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  assign jdpacc_tdo = dr_q[0];
  assign dp_write = write_q;
  assign dp_addr = addr_q;
  assign dp_wdata = wdata_q;
endmodule

// File: tb/tb_jtag_dpacc_dr.sv
// tb_jtag_dpacc_dr: scoreboard bench for the debug-port access data register.
module tb_jtag_dpacc_dr;
  localparam int AW = 8, DW = 32, DRW = 2 + AW + DW;
  logic tck = 1'b0, trst = 1'b1, tdi = 1'b0, tlr = 1'b0, cap = 1'b0, sft = 1'b0, upd = 1'b0, sel = 1'b1;
  logic dp_ack = 1'b0, dp_err = 1'b0;
  logic [DW-1:0] dp_rdata = '0;
  logic jdpacc_tdo, dp_req, dp_write;
  logic [AW-1:0] dp_addr;
  logic [DW-1:0] dp_wdata;
  logic q_tdo[$];
  logic [AW+DW:0] q_req[$];
  int n_tests = 0, n_fail = 0;
  jtag_dpacc_dr dut (
    .tck(tck), .trst(trst), .tdi(tdi), .state_test_logic_reset(tlr),
    .state_capture_dr(cap), .state_shift_dr(sft), .state_update_dr(upd),
    .insn_jdpacc_select(sel), .jdpacc_tdo(jdpacc_tdo), .dp_req(dp_req),
    .dp_write(dp_write), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_ack(dp_ack), .dp_err(dp_err), .dp_rdata(dp_rdata)
  );
  always #5 tck = ~tck;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge tck);
    #1;
  endtask
  function automatic logic [DRW-1:0] cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {d, a, op};
  endfunction
  function automatic logic [DRW-1:0] stat(input logic [DW-1:0] rd, input logic err, input logic busy);
    return {{AW{1'b0}}, rd, err, busy};
  endfunction
  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    q_req.push_back({w, a, d});
  endtask
  task automatic chk_bus();
    logic [AW+DW:0] e;
    chk("dp_req", dp_req, 1);
    if (q_req.size() == 0) chk("req_queue", 1, 0);
    else begin
      e = q_req.pop_front();
      chk("dp_write", dp_write, e[AW+DW]);
      chk("dp_addr", dp_addr, e[AW+DW-1:DW]);
      chk("dp_wdata", dp_wdata, e[DW-1:0]);
    end
  endtask
  task automatic capture();
    cap = 1'b1;
    tick();
    cap = 1'b0;
  endtask
  task automatic shift(input logic [DRW-1:0] din, input bit check);
    logic e;
    sft = 1'b1;
    for (int i = 0; i < DRW; i++) begin
      tdi = din[i];
      if (check) begin
        e = q_tdo.pop_front();
        chk($sformatf("tdo[%0d]", i), jdpacc_tdo, e);
      end
      tick();
    end
    sft = 1'b0;
  endtask
  task automatic update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask
  task automatic scan(input logic [DRW-1:0] din, input logic [DRW-1:0] exp_cap, input bit do_upd);
    for (int i = 0; i < DRW; i++) q_tdo.push_back(exp_cap[i]);
    capture();
    shift(din, 1'b1);
    if (do_upd) update();
  endtask
  task automatic ack(input logic [DW-1:0] rd, input logic err);
    dp_ack = 1'b1;
    dp_rdata = rd;
    dp_err = err;
    tick();
    dp_ack = 1'b0;
    dp_err = 1'b0;
    dp_rdata = '0;
  endtask
  initial begin
    tick();
    tick();
    trst = 1'b0;
    chk("rst_tdo", jdpacc_tdo, 0);
    chk("rst_req", dp_req, 0);
    shift('1, 1'b0);
    chk("ones_tdo", jdpacc_tdo, 1);
    trst = 1'b1;
    #2;
    chk("trst_tdo", jdpacc_tdo, 0);
    chk("trst_req", dp_req, 0);
    trst = 1'b0;
    tick();
    scan(cmd(2'b10, 8'h5A, 32'hDEADBEEF), '0, 1'b1);
    push_req(1'b1, 8'h5A, 32'hDEADBEEF);
    chk_bus();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", dp_req, 1);
      chk("hold_addr", dp_addr, 8'h5A);
    end
    ack(32'hFFFFFFFF, 1'b0);
    chk("wr_done_req", dp_req, 0);
    scan(cmd(2'b01, 8'h10, 32'h0), '0, 1'b1);
    push_req(1'b0, 8'h10, 32'h0);
    chk_bus();
    ack(32'h12345678, 1'b0);
    scan('0, stat(32'h12345678, 1'b0, 1'b0), 1'b1);
    chk("nop_req", dp_req, 0);
    scan(cmd(2'b01, 8'h33, 32'h0), stat(32'h12345678, 1'b0, 1'b0), 1'b1);
    push_req(1'b0, 8'h33, 32'h0);
    chk_bus();
    scan(cmd(2'b01, 8'h44, 32'h0), stat(32'h12345678, 1'b0, 1'b1), 1'b1);
    chk("ovr_req", dp_req, 1);
    chk("ovr_addr", dp_addr, 8'h33);
    ack(32'hA5A5A5A5, 1'b0);
    scan(cmd(2'b11, 8'h0, 32'h0), stat(32'hA5A5A5A5, 1'b1, 1'b0), 1'b1);
    scan('0, stat(32'hA5A5A5A5, 1'b0, 1'b0), 1'b1);
    scan(cmd(2'b10, 8'h01, 32'h55), stat(32'hA5A5A5A5, 1'b0, 1'b0), 1'b1);
    push_req(1'b1, 8'h01, 32'h55);
    chk_bus();
    ack(32'h0, 1'b1);
    scan(cmd(2'b11, 8'h0, 32'h0), stat(32'hA5A5A5A5, 1'b1, 1'b0), 1'b1);
    scan(cmd(2'b01, 8'h77, 32'h0BADF00D), stat(32'hA5A5A5A5, 1'b0, 1'b0), 1'b0);
    sel = 1'b0;
    sft = 1'b1;
    tdi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("desel_tdo", jdpacc_tdo, 1);
    end
    sft = 1'b0;
    update();
    chk("desel_upd_req", dp_req, 0);
    sel = 1'b1;
    update();
    push_req(1'b0, 8'h77, 32'h0BADF00D);
    chk_bus();
    ack(32'hCAFEF00D, 1'b0);
    scan(cmd(2'b10, 8'h66, 32'h1), stat(32'hCAFEF00D, 1'b0, 1'b0), 1'b1);
    push_req(1'b1, 8'h66, 32'h1);
    chk_bus();
    scan(cmd(2'b01, 8'h22, 32'h0), stat(32'hCAFEF00D, 1'b0, 1'b1), 1'b0);
    dp_ack = 1'b1;
    update();
    dp_ack = 1'b0;
    push_req(1'b0, 8'h22, 32'h0);
    chk_bus();
    scan(cmd(2'b11, 8'h0, 32'h0), stat(32'hCAFEF00D, 1'b0, 1'b1), 1'b0);
    dp_ack = 1'b1;
    dp_err = 1'b1;
    dp_rdata = 32'h13579BDF;
    update();
    dp_ack = 1'b0;
    dp_err = 1'b0;
    chk("b2b_done_req", dp_req, 0);
    scan('0, stat(32'h13579BDF, 1'b1, 1'b0), 1'b0);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    chk("tlr_tdo", jdpacc_tdo, 0);
    scan(cmd(2'b01, 8'h09, 32'h0), '0, 1'b1);
    push_req(1'b0, 8'h09, 32'h0);
    chk_bus();
    trst = 1'b1;
    #2;
    chk("midreq_req", dp_req, 0);
    trst = 1'b0;
    tick();
    ack(32'hFFFFFFFF, 1'b1);
    chk("late_ack_req", dp_req, 0);
    scan('0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
